// File: rtl/lc3b_types.sv
// Shared types for the LC-3b pipeline control: flow FSM states and the
// per-stage load/flush control vector with its canned patterns.
package lc3b_types;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } flow_state_e;

  // Field order doubles as the bit order of the canned patterns below.
  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic flush_mem_wb;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_IDLE       = 9'b00000_0000;
  localparam pipe_ctrl_t CTRL_ADVANCE    = 9'b11111_0000;
  // Everything upstream of MEM/WB frozen; MEM/WB takes a NOP.
  localparam pipe_ctrl_t CTRL_DMEM_STALL = 9'b00001_0001;
  localparam pipe_ctrl_t CTRL_REDIRECT   = 9'b11111_1110;
  // PC and IF/ID held, one NOP injected into ID/EX.
  localparam pipe_ctrl_t CTRL_HOLD_FRONT = 9'b00111_0100;
  // Late fetch of the wrong-path instruction arrives: drop it into IF/ID.
  localparam pipe_ctrl_t CTRL_DISCARD    = 9'b01111_1000;
  localparam pipe_ctrl_t CTRL_DISCARD_DS = 9'b01001_1001;

  localparam int NUM_PERF_CNT = 3;

  function automatic logic is_dmem_stall(input logic req, input logic resp);
    return req & ~resp;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_next = count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Five-stage pipeline flow control: stalls, bubbles, redirects and the
// late-fetch squash. Performance counters exist only with PIPE_FLOW_PERF_EN.
module pipe_flow_ctrl
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic gen_bubble,
  input  logic br_taken,
  input  logic imem_resp,
  input  logic dmem_req,
  input  logic dmem_resp,
  output logic load_pc,
  output logic load_if_id,
  output logic load_id_ex,
  output logic load_ex_mem,
  output logic load_mem_wb,
  output logic flush_if_id,
  output logic flush_id_ex,
  output logic flush_ex_mem,
  output logic flush_mem_wb
`ifdef PIPE_FLOW_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  flow_state_e state_reg;
  flow_state_e state_next;
  pipe_ctrl_t  ctrl;
  logic        dmem_stall;
  logic        stall_ev;
  logic        bubble_ev;
  logic        flush_ev;

  assign dmem_stall = is_dmem_stall(dmem_req, dmem_resp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    ctrl       = CTRL_IDLE;
    state_next = state_reg;
    stall_ev   = 1'b0;
    bubble_ev  = 1'b0;
    flush_ev   = 1'b0;
    case (state_reg)
      RUN: begin
        if (dmem_stall) begin
          ctrl     = CTRL_DMEM_STALL;
          stall_ev = 1'b1;
        end else if (br_taken) begin
          ctrl     = CTRL_REDIRECT;
          flush_ev = 1'b1;
          // A fetch still in flight belongs to the old path; kill it on arrival.
          if (!imem_resp) begin
            state_next = SQUASH;
          end
        end else if (!imem_resp) begin
          ctrl     = CTRL_HOLD_FRONT;
          stall_ev = 1'b1;
        end else if (gen_bubble) begin
          ctrl      = CTRL_HOLD_FRONT;
          bubble_ev = 1'b1;
        end else begin
          ctrl = CTRL_ADVANCE;
        end
      end
      SQUASH: begin
        if (imem_resp) begin
          ctrl       = dmem_stall ? CTRL_DISCARD_DS : CTRL_DISCARD;
          stall_ev   = dmem_stall;
          state_next = RUN;
        end else begin
          ctrl     = dmem_stall ? CTRL_DMEM_STALL : CTRL_HOLD_FRONT;
          stall_ev = 1'b1;
        end
      end
      default: begin
        ctrl       = CTRL_IDLE;
        state_next = RUN;
      end
    endcase
    if (!rst_n) begin
      ctrl = CTRL_IDLE;
    end
  end

  assign load_pc      = ctrl.load_pc;
  assign load_if_id   = ctrl.load_if_id;
  assign load_id_ex   = ctrl.load_id_ex;
  assign load_ex_mem  = ctrl.load_ex_mem;
  assign load_mem_wb  = ctrl.load_mem_wb;
  assign flush_if_id  = ctrl.flush_if_id;
  assign flush_id_ex  = ctrl.flush_id_ex;
  assign flush_ex_mem = ctrl.flush_ex_mem;
  assign flush_mem_wb = ctrl.flush_mem_wb;

`ifdef PIPE_FLOW_PERF_EN
  logic [NUM_PERF_CNT-1:0] perf_ev;
  logic [CNT_W-1:0]        perf_cnt [NUM_PERF_CNT];

  assign perf_ev = {flush_ev, bubble_ev, stall_ev};

  generate
    for (genvar gi = 0; gi < NUM_PERF_CNT; gi++) begin : g_perf
      sat_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (perf_ev[gi]),
        .count(perf_cnt[gi])
      );
    end
  endgenerate

  assign stall_cnt  = perf_cnt[0];
  assign bubble_cnt = perf_cnt[1];
  assign flush_cnt  = perf_cnt[2];
`else
  logic unused_perf_ev;
  assign unused_perf_ev = stall_ev ^ bubble_ev ^ flush_ev;
`endif

endmodule

// File: doc/pipe_flow_ctrl.md
PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each performance counter.
REQ-002 SHALL have ports: clk  in  1  pipeline clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: gen_bubble  in  1  load-use hazard on IF/ID vs ID/EX; br_taken  in  1  EX/MEM instruction redirects PC.
REQ-004 SHALL have ports: imem_resp  in  1  fetch complete this cycle; dmem_req  in  1  EX/MEM instruction accesses memory; dmem_resp  in  1  data access complete this cycle.
REQ-005 SHALL have outputs, each 1 bit: load_pc, load_if_id, load_id_ex, load_ex_mem and load_mem_wb (register enables); flush_if_id, flush_id_ex, flush_ex_mem and flush_mem_wb (load NOP instead of data).
REQ-006 SHALL have outputs stall_cnt, bubble_cnt and flush_cnt, each CNT_W wide (present only per REQ-020).

Function
REQ-007 SHALL implement FSM states RUN and SQUASH, with outputs combinational from state and inputs.
REQ-008 SHALL apply this priority in RUN: dmem stall > redirect > imem stall > load-use bubble > advance.
REQ-009 SHALL treat dmem_req=1 and dmem_resp=0 as a dmem stall: all load_*=0 except load_mem_wb=1 with flush_mem_wb=1.
REQ-010 SHALL, on a RUN redirect (br_taken=1, no dmem stall), drive all load_*=1 and flush_if_id=flush_id_ex=flush_ex_mem=1.
REQ-011 SHALL, on a REQ-010 redirect with imem_resp=0, go to SQUASH next cycle; with imem_resp=1, stay in RUN.
REQ-012 SHALL, on a RUN imem stall (imem_resp=0), drive load_pc=load_if_id=0 and load_id_ex=flush_id_ex=1, with remaining loads 1.
REQ-013 SHALL, on a RUN load-use bubble (gen_bubble=1, imem_resp=1), drive the same outputs as REQ-012 (PC and IF/ID held, one NOP into ID/EX).
REQ-014 SHALL, on a RUN advance, drive all load_*=1 and all flush_*=0.
REQ-015 SHALL, in SQUASH with imem_resp=1, drive load_if_id=flush_if_id=1 and load_pc=0, then return to RUN; this holds even during a dmem stall.
REQ-016 SHALL, in SQUASH with imem_resp=0, drive outputs per REQ-012, or per REQ-009 if a dmem stall is present.
REQ-017 SHALL ignore gen_bubble and br_taken while in SQUASH.
REQ-018 SHALL give one cycle of latency between a redirect with pending fetch and the SQUASH discard; all other responses are zero-latency.

Reset
REQ-019 SHALL, while rst_n=0, force state RUN, all load_*=0, all flush_*=0 and counters 0, asynchronously, including when asserted mid-SQUASH.

Configuration
REQ-020 SHALL include stall_cnt, bubble_cnt and flush_cnt only when PIPE_FLOW_PERF_EN is defined; without it the ports and counters do not exist and all other behaviour is identical.
REQ-021 SHALL, with PIPE_FLOW_PERF_EN defined, count as follows, each counter saturating at all-ones:
- stall_cnt: +1 per dmem- or imem-stall cycle.
- bubble_cnt: +1 per REQ-013 cycle.
- flush_cnt: +1 per REQ-010 cycle.

Structure
REQ-022 SHALL place the FSM state enum (RUN, SQUASH) in the shared lc3b_types package.
REQ-023 SHALL use the sub-module sat_counter (parameter CNT_W, ports clk, rst_n, inc, count), instantiated three times.

Verification
REQ-024 SHALL cover: gen_bubble=1 for 1 cycle, imem_resp=1 -> load_pc=0, load_if_id=0, flush_id_ex=1; next cycle all loads 1; bubble_cnt=1.
REQ-025 SHALL cover: dmem_req=1 with dmem_resp=0 for 3 cycles, then 1 -> 3 cycles with only load_mem_wb=1 and flush_mem_wb=1; stall_cnt=3.
REQ-026 SHALL cover: br_taken=1 with imem_resp=1 -> flush_if_id, flush_id_ex and flush_ex_mem all 1, state stays RUN; flush_cnt=1.
REQ-027 SHALL cover: br_taken=1 with imem_resp=0, then imem_resp=1 two cycles later -> SQUASH entered, discard cycle flush_if_id=1 with load_pc=0, then RUN.
REQ-028 SHALL cover: in SQUASH, imem_resp=1 concurrent with a dmem stall -> flush_if_id=1, load_if_id=1, load_id_ex=0, next state RUN.
REQ-029 SHALL cover: rst_n low mid-SQUASH -> immediate loads/flushes 0 and counters 0; after release, first cycle with imem_resp=1 advances normally.
